risc_imem: RTL



---
 rtl/risc_pkg.sv | 16 +
 rtl/risc_imem_loader.sv | 88 ++++++++
 rtl/risc_imem.sv | 92 +++++++++
 3 files changed

// File: rtl/risc_pkg.sv
// Shared definitions for the risc instruction memory: default widths,
// the NOP encoding returned for unwritten words, and the loader state enum.
package risc_pkg;

   localparam int RISC_DATA_W = 13;
   localparam int RISC_ADDR_W = 5;

   localparam logic [RISC_DATA_W-1:0] NOP = 13'h0000;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2
   } state_t;

endpackage

// File: rtl/risc_imem_loader.sv
// Load-port controller for risc_imem: owns the IDLE/LOAD/RUN state machine,
// the write pointer and the count of words written since the last load_start.
// It tells the memory when and where to write and when to wipe the valid bits.
module risc_imem_loader
   import risc_pkg::*;
#(
   parameter int ADDR_W = RISC_ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_loadStart,
   input  logic              i_loadValid,
   input  logic              i_loadDone,
   output logic              o_we,
   output logic [ADDR_W-1:0] o_waddr,
   output logic              o_clear,
   output logic              o_loadReady,
   output logic              o_run,
   output logic [ADDR_W:0]   o_count
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

   state_t            r_state;
   state_t            w_nextState;
   logic [ADDR_W-1:0] r_ptr;
   logic [ADDR_W-1:0] w_nextPtr;
   logic [ADDR_W:0]   r_count;
   logic [ADDR_W:0]   w_nextCount;
   logic              w_we;
   logic              w_clear;

   // State, pointer and count registers; reset returns to IDLE with nothing loaded.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_ptr   <= '0;
         r_count <= '0;
      end else begin
         r_state <= w_nextState;
         r_ptr   <= w_nextPtr;
         r_count <= w_nextCount;
      end
   end

   // Next-state logic: load_start wins over everything, otherwise LOAD accepts
   // words until the last address is written or load_done ends it early.
   always_comb begin
      w_nextState = r_state;
      w_nextPtr   = r_ptr;
      w_nextCount = r_count;
      w_we        = 1'b0;
      w_clear     = 1'b0;
      if (i_loadStart) begin
         w_nextState = LOAD;
         w_nextPtr   = '0;
         w_nextCount = '0;
         w_clear     = 1'b1;
      end else begin
         case (r_state)
            LOAD: begin
               if (i_loadValid) begin
                  w_we        = 1'b1;
                  w_nextPtr   = r_ptr + ADDR_W'(1);
                  w_nextCount = r_count + (ADDR_W+1)'(1);
                  if (r_ptr == LAST_ADDR) begin
                     w_nextState = RUN;
                  end
               end
               if (i_loadDone) begin
                  w_nextState = RUN;
               end
            end
            default: begin
               w_nextState = r_state;
            end
         endcase
      end
   end

   assign o_we        = w_we;
   assign o_waddr     = r_ptr;
   assign o_clear     = w_clear;
   assign o_loadReady = (r_state == LOAD);
   assign o_run       = (r_state == RUN);
   assign o_count     = r_count;

endmodule

// File: rtl/risc_imem.sv
// Instruction memory serving the instruction unit's fetch port. Words are
// loaded sequentially through a ready/valid port; unwritten words read as NOP.
// Build option RISC_IMEM_COMB_READ_EN: when defined, the fetch path is
// combinational (zero latency); otherwise instruction is registered (1 cycle).
module risc_imem
   import risc_pkg::*;
#(
   parameter int DATA_W = RISC_DATA_W,
   parameter int ADDR_W = RISC_ADDR_W,
   parameter int DEPTH  = 2**ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] pc,
   output logic [DATA_W-1:0] instruction,
   input  logic              load_start,
   input  logic              load_valid,
   input  logic [DATA_W-1:0] load_data,
   output logic              load_ready,
   input  logic              load_done,
   output logic              run,
   output logic [ADDR_W:0]   load_count
);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DEPTH-1:0]  r_valid;
   logic              w_we;
   logic [ADDR_W-1:0] w_waddr;
   logic              w_clear;
   logic              w_run;
   logic [DATA_W-1:0] w_fetch;

   risc_imem_loader #(
      .ADDR_W (ADDR_W)
   ) u_loader (
      .clk         (clk),
      .rst         (rst),
      .i_loadStart (load_start),
      .i_loadValid (load_valid),
      .i_loadDone  (load_done),
      .o_we        (w_we),
      .o_waddr     (w_waddr),
      .o_clear     (w_clear),
      .o_loadReady (load_ready),
      .o_run       (w_run),
      .o_count     (load_count)
   );

   assign run = w_run;

   // Storage array; deliberately not reset, the valid bits hide stale contents.
   always_ff @(posedge clk) begin
      if (w_we) begin
         r_mem[w_waddr] <= load_data;
      end
   end

   // Per-word valid bits: wiped by reset or a new load, set as each word lands.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid <= '0;
      end else if (w_clear) begin
         r_valid <= '0;
      end else if (w_we) begin
         r_valid[w_waddr] <= 1'b1;
      end
   end

   assign w_fetch = r_valid[pc] ? r_mem[pc] : NOP;

`ifdef RISC_IMEM_COMB_READ_EN
   assign instruction = w_run ? w_fetch : NOP;
`else
   logic [DATA_W-1:0] r_instruction;

   // Registered fetch: one cycle from pc to instruction, NOP whenever not serving.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_instruction <= NOP;
      end else if (load_start) begin
         r_instruction <= NOP;
      end else if (w_run) begin
         r_instruction <= w_fetch;
      end else begin
         r_instruction <= NOP;
      end
   end

   assign instruction = r_instruction;
`endif

endmodule
